id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
Parametrised successor decode stage for the RISC-V core pipeline, sitting between fetch (IF) and execute (EX).
- Selects the fetched instruction from BIOS or IMEM.
- Reads an internal register file with write-first bypass, then resolves operands through N forwarding sources.
- Generates the immediate and detects load-use hazards.
- Registers everything into an ID/EX pipeline register with valid, stall and flush handling.
- Adds a saturating stall-cycle counter for performance debug.

Parameters:
XLEN, 32, datapath width.
NREGS, 32, number of architectural registers; register index width is $clog2(NREGS).
NUM_FWD, 3, number of forwarding sources; index 0 is youngest (EX), ascending is older (MEM, WB...).
INST_SEL_BIT, 30, PC bit that selects the instruction source: 0 = BIOS, 1 = IMEM.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
if_valid  in  1  IF holds a valid instruction.
if_pc  in  XLEN  PC of the fetched instruction.
if_bios_inst  in  32  instruction word from BIOS.
if_imem_inst  in  32  instruction word from IMEM.
id_ready  out  1  ID accepts the IF instruction this cycle (combinational).
ex_ready  in  1  EX accepts the ID/EX register contents this cycle.
flush  in  1  kill the instruction in ID and the one being accepted (branch/jump redirect).
wb_regwen  in  1  register-file write enable.
wb_wa  in  log2(NREGS)  write address.
wb_wdata  in  XLEN  write data.
fwd_valid  in  NUM_FWD  source i holds a register-writing instruction.
fwd_pending  in  NUM_FWD  source i result is not yet available (load in flight).
fwd_rd  in  NUM_FWD*log2(NREGS)  destination register of each source.
fwd_data  in  NUM_FWD*XLEN  result of each source.
id_valid  out  1  ID/EX register holds a valid instruction.
id_pc  out  XLEN  registered PC.
id_rs1_val  out  XLEN  registered, forwarded rs1 value.
id_rs2_val  out  XLEN  registered, forwarded rs2 value.
id_imm  out  XLEN  registered, sign-extended immediate.
id_inst  out  32  registered instruction.
stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (async, immediate):
  - id_valid = 0; id_pc, id_rs1_val, id_rs2_val, id_imm = 0.
  - id_inst = 32'h0000_0013 (NOP).
  - stall_count = 0; all register-file entries = 0.
- Instruction select: inst = if_pc[INST_SEL_BIT] ? if_imem_inst : if_bios_inst.
- Register file:
  - x0 reads 0 and ignores writes.
  - Write-first: a read of wb_wa while wb_regwen is set (wa != 0) returns wb_wdata in the same cycle.
- Forwarding, per operand (rs1 = inst[19:15], rs2 = inst[24:20]):
  - Source i matches when fwd_valid[i] and fwd_rd[i] == rs and rs != 0.
  - The lowest-index match wins; with no match, the register-file value is used.
- Hazard:
  - hazard = if_valid and the winning match for a used operand has fwd_pending set.
  - Operand use is decoded from opcode: U/J types use neither operand; I-type uses rs1 only.
- Immediate: I/S/B/U/J formats selected by opcode[6:2]; unknown opcodes give 0. Sign extension is to XLEN.
- Handshake:
  - advance = ex_ready or not id_valid.
  - id_ready = advance and not hazard.
- Register update, by priority:
  1. flush: id_valid <= 0; data registers hold. Flush overrides hazard and advance.
  2. advance and hazard: id_valid <= 0 (bubble inserted); data registers hold.
  3. advance and not hazard: all registers load; id_valid <= if_valid.
  4. not advance: all registers hold.
- Latency: 1 cycle from IF acceptance to id_valid.
- stall_count:
  - Increments each cycle where if_valid and hazard and not flush.
  - Saturates at all-ones; it does not wrap.
- Simultaneous WB write and forward match: the forwarding source has priority over the register-file bypass.

Decomposition:
- Shared package rv_decode_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG);
  - the imm-type encoding (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J);
  - the NOP_INST constant.
- Sub-module reg_file_bypass(NREGS, XLEN): 2 read ports, 1 write port, async reset, write-first bypass, x0 hardwired.

Test Plan:
- Reset mid-run with id_valid = 1: assert rst -> outputs zero immediately, id_inst = 0x00000013; after release, stall_count = 0.
- addi x1,x0,5 (0x00500093) at pc 0x40000000, if_valid = 1, ex_ready = 1 -> next cycle id_valid = 1, id_imm = 5, id_pc = 0x40000000, IMEM word selected.
- add x3,x1,x2 with fwd_valid = 3'b011, fwd_rd = {x1,x1,x1}, fwd_data = {0x33,0x22,0x11} -> id_rs1_val = 0x11 (source 0 wins).
- Same add with source 0 matching x1 and fwd_pending[0] = 1, held 2 cycles -> id_ready = 0, id_valid = 0 for 2 cycles, stall_count = 2; on release the instruction loads.
- ex_ready = 0 while id_valid = 1 -> all outputs hold, id_ready = 0; flush while stalled -> id_valid = 0 next cycle and no stall_count increment.
- WB writes x5 = 0xDEADBEEF while decoding add x6,x5,x0, no forwarding -> id_rs1_val = 0xDEADBEEF; a write to x0 -> reads remain 0.

Source files
------------

// File: rtl/rv_decode_pkg.sv
`default_nettype none
// ============================================================================
// rv_decode_pkg : RV32 opcode, immediate-format and NOP constants for decode
// Revision      : 1.0
// ============================================================================
package rv_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Format is chosen on opcode[6:2]; the two low bits are always 2'b11 in RV32.
    function automatic imm_type_e imm_type(input logic [6:0] op);
        case (op[6:2])
            OP_LOAD[6:2], OP_IMM[6:2], OP_JALR[6:2]: return IMM_I;
            OP_STORE[6:2]:                           return IMM_S;
            OP_BRANCH[6:2]:                          return IMM_B;
            OP_LUI[6:2], OP_AUIPC[6:2]:              return IMM_U;
            OP_JAL[6:2]:                             return IMM_J;
            default:                                 return IMM_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_bypass.sv
`default_nettype none
// ============================================================================
// reg_file_bypass : 2R1W register file, x0 hardwired, write-first read bypass
// Revision        : 1.0
// ============================================================================
module reg_file_bypass #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr;

    assign w_wr = wen && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[wa] <= wdata;
        end
    end

    // Same-cycle write data is returned so WB results need no extra forward path.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : (w_wr && wa == ra1) ? wdata : r_regs[ra1];
        rd2 = (ra2 == '0) ? '0 : (w_wr && wa == ra2) ? wdata : r_regs[ra2];
    end

endmodule
`default_nettype wire

// File: rtl/id_stage_fwd.sv
`default_nettype none
// ============================================================================
// id_stage_fwd : decode stage with operand forwarding, load-use stall and ID/EX reg
// Revision     : 1.0
// ============================================================================
module id_stage_fwd
    import rv_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int NUM_FWD      = 3,
    parameter int INST_SEL_BIT = 30,
    parameter int CNT_W        = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             if_valid,
    input  logic [XLEN-1:0]                  if_pc,
    input  logic [31:0]                      if_bios_inst,
    input  logic [31:0]                      if_imem_inst,
    output logic                             id_ready,
    input  logic                             ex_ready,
    input  logic                             flush,
    input  logic                             wb_regwen,
    input  logic [$clog2(NREGS)-1:0]         wb_wa,
    input  logic [XLEN-1:0]                  wb_wdata,
    input  logic [NUM_FWD-1:0]               fwd_valid,
    input  logic [NUM_FWD-1:0]               fwd_pending,
    input  logic [NUM_FWD*$clog2(NREGS)-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]          fwd_data,
    output logic                             id_valid,
    output logic [XLEN-1:0]                  id_pc,
    output logic [XLEN-1:0]                  id_rs1_val,
    output logic [XLEN-1:0]                  id_rs2_val,
    output logic [XLEN-1:0]                  id_imm,
    output logic [31:0]                      id_inst,
    output logic [CNT_W-1:0]                 stall_count
);

    localparam int RW = $clog2(NREGS);

    logic [31:0]     w_inst;
    logic [6:0]      w_op;
    logic [RW-1:0]   w_rs1;
    logic [RW-1:0]   w_rs2;
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_pend;
    logic            w_rs2_pend;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_hazard;
    logic            w_advance;
    logic [XLEN-1:0] w_imm;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic [31:0]     r_inst;
    logic [CNT_W-1:0] r_stall;

    assign w_inst = if_pc[INST_SEL_BIT] ? if_imem_inst : if_bios_inst;
    assign w_op   = w_inst[6:0];
    assign w_rs1  = w_inst[15 +: RW];
    assign w_rs2  = w_inst[20 +: RW];

    reg_file_bypass #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .wen   (wb_regwen),
        .wa    (wb_wa),
        .wdata (wb_wdata),
        .ra1   (w_rs1),
        .ra2   (w_rs2),
        .rd1   (w_rf_rd1),
        .rd2   (w_rf_rd2)
    );

    // Walk oldest to youngest so the lowest-index match is the last to win.
    always_comb begin
        w_rs1_val  = w_rf_rd1;
        w_rs2_val  = w_rf_rd2;
        w_rs1_pend = 1'b0;
        w_rs2_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_rd[i*RW +: RW] == w_rs1 && w_rs1 != '0) begin
                w_rs1_val  = fwd_data[i*XLEN +: XLEN];
                w_rs1_pend = fwd_pending[i];
            end
            if (fwd_valid[i] && fwd_rd[i*RW +: RW] == w_rs2 && w_rs2 != '0) begin
                w_rs2_val  = fwd_data[i*XLEN +: XLEN];
                w_rs2_pend = fwd_pending[i];
            end
        end
    end

    assign w_use_rs1 = !(w_op == OP_LUI || w_op == OP_AUIPC || w_op == OP_JAL);
    assign w_use_rs2 = w_use_rs1 && !(w_op == OP_IMM || w_op == OP_LOAD || w_op == OP_JALR);
    assign w_hazard  = if_valid && ((w_use_rs1 && w_rs1_pend) || (w_use_rs2 && w_rs2_pend));
    assign w_advance = ex_ready || !r_valid;
    assign id_ready  = w_advance && !w_hazard;

    always_comb begin
        w_imm = '0;
        case (imm_type(w_op))
            IMM_I:   w_imm = {{(XLEN-11){w_inst[31]}}, w_inst[30:20]};
            IMM_S:   w_imm = {{(XLEN-11){w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
            IMM_B:   w_imm = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
            IMM_U:   w_imm = {{(XLEN-31){w_inst[31]}}, w_inst[30:12], 12'b0};
            IMM_J:   w_imm = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_inst    <= NOP_INST;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_hazard) begin
                r_valid <= 1'b0;
            end else begin
                r_valid   <= if_valid;
                r_pc      <= if_pc;
                r_rs1_val <= w_rs1_val;
                r_rs2_val <= w_rs2_val;
                r_imm     <= w_imm;
                r_inst    <= w_inst;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_hazard && !flush && r_stall != {CNT_W{1'b1}}) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign id_valid    = r_valid;
    assign id_pc       = r_pc;
    assign id_rs1_val  = r_rs1_val;
    assign id_rs2_val  = r_rs2_val;
    assign id_imm      = r_imm;
    assign id_inst     = r_inst;
    assign stall_count = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_fwd.sv
`default_nettype none
// ============================================================================
// tb_id_stage_fwd : directed + random bench for id_stage_fwd against a reference model
// Revision        : 1.0
// ============================================================================
module tb_id_stage_fwd;

    localparam int XLEN    = 32;
    localparam int NREGS   = 32;
    localparam int NUM_FWD = 3;
    localparam int CNT_W   = 4;
    localparam int CMAX    = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc, if_bios_inst, if_imem_inst;
    logic        id_ready, ex_ready, flush, wb_regwen;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wdata;
    logic [2:0]  fwd_valid, fwd_pending;
    logic [14:0] fwd_rd;
    logic [95:0] fwd_data;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm, id_inst;
    logic [CNT_W-1:0] stall_count;

    id_stage_fwd #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_FWD(NUM_FWD), .INST_SEL_BIT(30), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
        .if_bios_inst(if_bios_inst), .if_imem_inst(if_imem_inst), .id_ready(id_ready),
        .ex_ready(ex_ready), .flush(flush), .wb_regwen(wb_regwen), .wb_wa(wb_wa),
        .wb_wdata(wb_wdata), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_inst(id_inst), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_inst;
    int          m_stall;
    logic [31:0] m_regs [32];
    logic        exp_ready, obs_ready;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_regwen && wb_wa == r) return wb_wdata;
        return m_regs[r];
    endfunction

    function automatic void m_operand(input logic [4:0] r, output logic [31:0] v, output logic pend);
        v    = m_read(r);
        pend = 1'b0;
        if (r != 5'd0) begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (fwd_valid[i] && fwd_rd[i*5 +: 5] == r) begin
                    v    = fwd_data[i*32 +: 32];
                    pend = fwd_pending[i];
                    break;
                end
            end
        end
    endfunction

    function automatic logic [31:0] m_immf(input logic [31:0] in);
        logic [31:0] sx12, sx13, sx21;
        sx12 = in[31] ? 32'hFFFF_F800 : 32'h0;
        sx13 = in[31] ? 32'hFFFF_F000 : 32'h0;
        sx21 = in[31] ? 32'hFFF0_0000 : 32'h0;
        case (in[6:2])
            5'b00000, 5'b00100, 5'b11001: return sx12 | {21'd0, in[30:20]};
            5'b01000:                     return sx12 | {21'd0, in[30:25], in[11:7]};
            5'b11000:                     return sx13 | {20'd0, in[7], in[30:25], in[11:8], 1'b0};
            5'b01101, 5'b00101:           return {in[31:12], 12'd0};
            5'b11011:                     return sx21 | {12'd0, in[19:12], in[20], in[30:21], 1'b0};
            default:                      return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
        m_inst = 32'h0000_0013; m_stall = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic idle_inputs();
        if_valid = 0; if_pc = 0; if_bios_inst = 32'h13; if_imem_inst = 32'h13;
        ex_ready = 1; flush = 0; wb_regwen = 0; wb_wa = 0; wb_wdata = 0;
        fwd_valid = 0; fwd_pending = 0; fwd_rd = 0; fwd_data = 0;
    endtask

    // One clock: evaluate the model against the inputs currently driven, then clock.
    task automatic step();
        logic [31:0] inst, v1, v2;
        logic        p1, p2, u1, u2, hz, adv;
        #1;
        inst = if_pc[30] ? if_imem_inst : if_bios_inst;
        m_operand(inst[19:15], v1, p1);
        m_operand(inst[24:20], v2, p2);
        u1  = !(inst[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2  = u1 && !(inst[6:0] inside {7'b0010011, 7'b0000011, 7'b1100111});
        hz  = if_valid && ((u1 && p1) || (u2 && p2));
        adv = ex_ready || !m_valid;
        exp_ready = adv && !hz;
        obs_ready = id_ready;
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (adv && hz) m_valid = 1'b0;
        else if (adv) begin
            m_valid = if_valid; m_pc = if_pc; m_rs1 = v1; m_rs2 = v2;
            m_imm = m_immf(inst); m_inst = inst;
        end
        if (hz && !flush && m_stall < CMAX) m_stall++;
        if (wb_regwen && wb_wa != 0) m_regs[wb_wa] = wb_wdata;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0050_0093;
        step();
        if_imem_inst = 32'h0020_81B3;
        fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1};
        step();
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0050_0093;
        step();
        checks++;
        if (id_valid !== 1'b1 || stall_count !== 4'd1) begin
            failures++;
            $display("FAIL reset_pre valid=%b stall=%0d required valid=1 stall=1", id_valid, stall_count);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 0 || id_rs1_val !== 0 || id_rs2_val !== 0 || id_imm !== 0) begin
            failures++;
            $display("FAIL reset_zero valid=%b pc=%h rs1=%h rs2=%h imm=%h required all zero",
                     id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm);
        end
        checks++;
        if (id_inst !== 32'h0000_0013) begin
            failures++;
            $display("FAIL reset_nop inst=%h required 00000013", id_inst);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        step();
        checks++;
        if (stall_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_stall count=%0d required 0", stall_count);
        end
    endtask

    task automatic test_addi();
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0050_0093; if_bios_inst = 32'h00A0_0113;
        step();
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++; $display("FAIL addi_ready ready=%b required 1", obs_ready);
        end
        checks++;
        if (id_valid !== 1'b1 || id_imm !== 32'd5 || id_pc !== 32'h4000_0000 || id_inst !== 32'h0050_0093) begin
            failures++;
            $display("FAIL addi_imem valid=%b imm=%h pc=%h inst=%h required 1 5 40000000 00500093",
                     id_valid, id_imm, id_pc, id_inst);
        end
        if_pc = 32'h0000_1000;
        step();
        checks++;
        if (id_inst !== 32'h00A0_0113 || id_imm !== 32'd10) begin
            failures++;
            $display("FAIL addi_bios inst=%h imm=%h required 00a00113 a", id_inst, id_imm);
        end
    endtask

    task automatic test_fwd_priority();
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0020_81B3;
        fwd_rd = {5'd1, 5'd1, 5'd1}; fwd_data = {32'h33, 32'h22, 32'h11};
        fwd_valid = 3'b011;
        step();
        checks++;
        if (id_rs1_val !== 32'h11) begin
            failures++; $display("FAIL fwd_src0 rs1=%h required 11", id_rs1_val);
        end
        fwd_valid = 3'b100;
        step();
        checks++;
        if (id_rs1_val !== 32'h33 || id_rs2_val !== m_rs2) begin
            failures++; $display("FAIL fwd_src2 rs1=%h rs2=%h required 33 %h", id_rs1_val, id_rs2_val, m_rs2);
        end
    endtask

    task automatic test_load_use();
        int base;
        base = m_stall;
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0020_81B3;
        fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1}; fwd_data = {64'd0, 32'hABCD};
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (obs_ready !== 1'b0 || id_valid !== 1'b0) begin
                failures++; $display("FAIL loaduse_stall ready=%b valid=%b required 0 0", obs_ready, id_valid);
            end
        end
        checks++;
        if (stall_count !== CNT_W'(base + 2)) begin
            failures++; $display("FAIL loaduse_count count=%0d required %0d", stall_count, base + 2);
        end
        fwd_pending = 3'b000;
        step();
        checks++;
        if (id_valid !== 1'b1 || id_rs1_val !== 32'hABCD) begin
            failures++; $display("FAIL loaduse_release valid=%b rs1=%h required 1 abcd", id_valid, id_rs1_val);
        end
    endtask

    task automatic test_backpressure_flush();
        logic [31:0] hold_pc, hold_inst, hold_rs1;
        int base;
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0100; if_imem_inst = 32'h0050_0093;
        step();
        hold_pc = m_pc; hold_inst = m_inst; hold_rs1 = m_rs1;
        base = m_stall;
        ex_ready = 0; if_pc = 32'h4000_0200; if_imem_inst = 32'h0020_81B3;
        step();
        checks++;
        if (obs_ready !== 1'b0 || id_valid !== 1'b1 || id_pc !== hold_pc || id_inst !== hold_inst || id_rs1_val !== hold_rs1) begin
            failures++;
            $display("FAIL backpressure_hold ready=%b valid=%b pc=%h inst=%h required 0 1 %h %h",
                     obs_ready, id_valid, id_pc, id_inst, hold_pc, hold_inst);
        end
        flush = 1; fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1};
        step();
        checks++;
        if (id_valid !== 1'b0 || stall_count !== CNT_W'(base)) begin
            failures++; $display("FAIL flush_stalled valid=%b count=%0d required 0 %0d", id_valid, stall_count, base);
        end
    endtask

    task automatic test_wb_bypass();
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0002_8333;
        wb_regwen = 1; wb_wa = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if (id_rs1_val !== 32'hDEAD_BEEF || id_rs2_val !== 32'd0) begin
            failures++; $display("FAIL wb_bypass rs1=%h rs2=%h required deadbeef 0", id_rs1_val, id_rs2_val);
        end
        wb_regwen = 0;
        step();
        checks++;
        if (id_rs1_val !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wb_stored rs1=%h required deadbeef", id_rs1_val);
        end
        if_imem_inst = 32'h0000_0333; wb_regwen = 1; wb_wa = 5'd0; wb_wdata = 32'h1234_5678;
        step();
        step();
        checks++;
        if (id_rs1_val !== 32'd0 || id_rs2_val !== 32'd0) begin
            failures++; $display("FAIL wb_x0 rs1=%h rs2=%h required 0 0", id_rs1_val, id_rs2_val);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        if_valid = 1; if_pc = 32'h4000_0000; if_imem_inst = 32'h0020_81B3;
        fwd_valid = 3'b010; fwd_pending = 3'b010; fwd_rd = {5'd0, 5'd2, 5'd0};
        for (int k = 0; k < CMAX + 5; k++) step();
        checks++;
        if (stall_count !== 4'hF) begin
            failures++; $display("FAIL stall_saturate count=%0d required 15", stall_count);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] inst;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
        for (int n = 0; n < 400; n++) begin
            inst = $urandom;
            inst[6:0]   = ops[$urandom_range(0, 9)];
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            if_valid     = ($urandom_range(0, 9) < 8);
            if_pc        = $urandom;
            if_bios_inst = if_pc[30] ? $urandom : inst;
            if_imem_inst = if_pc[30] ? inst : $urandom;
            ex_ready     = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 9) == 0);
            wb_regwen    = $urandom_range(0, 1);
            wb_wa        = 5'($urandom_range(0, 7));
            wb_wdata     = $urandom;
            fwd_valid    = 3'($urandom);
            fwd_pending  = 3'(($urandom_range(0, 4) == 0) ? $urandom : 0);
            for (int i = 0; i < NUM_FWD; i++) begin
                fwd_rd[i*5 +: 5]    = 5'($urandom_range(0, 7));
                fwd_data[i*32 +: 32] = $urandom;
            end
            step();
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready n=%0d got=%b required=%b", n, obs_ready, exp_ready);
            end
            checks++;
            if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst) begin
                failures++;
                $display("FAIL rand_ctl n=%0d valid=%b pc=%h inst=%h required %b %h %h",
                         n, id_valid, id_pc, id_inst, m_valid, m_pc, m_inst);
            end
            checks++;
            if (id_rs1_val !== m_rs1 || id_rs2_val !== m_rs2 || id_imm !== m_imm) begin
                failures++;
                $display("FAIL rand_data n=%0d rs1=%h rs2=%h imm=%h required %h %h %h",
                         n, id_rs1_val, id_rs2_val, id_imm, m_rs1, m_rs2, m_imm);
            end
            checks++;
            if (stall_count !== CNT_W'(m_stall)) begin
                failures++; $display("FAIL rand_stall n=%0d got=%0d required=%0d", n, stall_count, m_stall);
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_addi();
        test_fwd_priority();
        test_load_use();
        test_backpressure_flush();
        test_wb_bypass();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
